// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result path.
//   DW / field offsets : layout of one packed complex sample
//   N_LOG2_DEFAULT     : default log2 frame length
//   cplx_t             : packed complex sample
//   collect_state_t    : output collector FSM states
//   bitrev()           : reverses the low w bits of an index
package fft_pkg;

  localparam int DW             = 34;
  localparam int RE_SIGN        = 33;
  localparam int RE_INT_MSB     = 32;
  localparam int RE_FRAC_LSB    = 17;
  localparam int IM_SIGN        = 16;
  localparam int IM_FRAC_LSB    = 0;

  localparam int N_LOG2_DEFAULT = 4;

  // Widest index the reverser handles; frames are far smaller than 2**16.
  localparam int BITREV_MAX_W   = 16;
  localparam int BITREV_IDX_W   = 4;

  typedef struct packed {
    logic       re_sign;
    logic [7:0] re_int;
    logic [7:0] re_frac;
    logic       im_sign;
    logic [7:0] im_int;
    logic [7:0] im_frac;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } collect_state_t;

  // Bits at and above w are returned as zero. w is a constant at every
  // call site, so the loop folds down to pure wiring.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] v,
    input int                      w
  );
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) begin
        r[BITREV_IDX_W'(i)] = v[BITREV_IDX_W'(w - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Combinational N_LOG2-bit index reverser used for the input-side loader.
//   idx : arrival index
//   rev : idx with its bit order reversed
module fft_bitrev_addr #(
  parameter int N_LOG2 = fft_pkg::N_LOG2_DEFAULT
) (
  input  logic [N_LOG2-1:0] idx,
  output logic [N_LOG2-1:0] rev
);
  import fft_pkg::*;

  logic [BITREV_MAX_W-1:0] rev_wide;

  always_comb begin
    rev_wide = bitrev(BITREV_MAX_W'(idx), N_LOG2);
  end

  assign rev = rev_wide[N_LOG2-1:0];

endmodule

// File: rtl/fft_out_collector.sv
// Captures one frame of N FFT results, undoes the bit-reversed arrival
// order and drains the frame in natural bin order over valid/ready.
//   clk, rst       : clock, async active-high reset
//   in_valid/first : input sample strobe and start-of-frame marker
//   in_data        : packed complex sample
//   out_valid/ready: output handshake
//   out_data       : sample of bin out_index (zero when idle)
//   out_last       : marks bin N-1
//   busy           : frame being filled or drained
//   frame_err      : one-cycle pulse when a frame restarts mid-fill
//   drop_cnt       : saturating count of discarded input samples
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for in_first; other samples are dropped
// FILL  | writing samples into the buffer at (bit-reversed) wr_cnt
// DRAIN | presenting buf[rd_ptr]; input dropped except a new frame
//       | start coinciding with the final transfer
module fft_out_collector #(
  parameter int N_LOG2 = fft_pkg::N_LOG2_DEFAULT,
  parameter int DW     = fft_pkg::DW,
  parameter int BITREV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [N_LOG2-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        drop_cnt
);
  import fft_pkg::*;

  localparam int                N        = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST_IDX = '1;

  collect_state_t    state, state_nxt;
  logic [N_LOG2-1:0] wr_cnt, wr_cnt_nxt;
  logic [N_LOG2-1:0] rd_ptr, rd_ptr_nxt;
  logic [N_LOG2-1:0] wr_idx, wr_idx_rev, wr_addr;
  logic              wr_en;
  logic              drop;
  logic              frame_err_nxt;

  logic [DW-1:0]     sample_buf [N];

  fft_bitrev_addr #(.N_LOG2(N_LOG2)) u_bitrev (
    .idx (wr_idx),
    .rev (wr_idx_rev)
  );

  always_comb begin
    wr_addr = (BITREV != 0) ? wr_idx_rev : wr_idx;
  end

  always_comb begin
    state_nxt     = state;
    wr_cnt_nxt    = wr_cnt;
    rd_ptr_nxt    = rd_ptr;
    wr_idx        = wr_cnt;
    wr_en         = 1'b0;
    drop          = 1'b0;
    frame_err_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (in_valid && in_first) begin
          wr_en      = 1'b1;
          wr_idx     = '0;
          wr_cnt_nxt = N_LOG2'(1);
          state_nxt  = ST_FILL;
        end else if (in_valid) begin
          drop = 1'b1;
        end
      end

      ST_FILL: begin
        if (in_valid && in_first) begin
          // Restart: the partial frame is abandoned, not counted as drops.
          wr_en         = 1'b1;
          wr_idx        = '0;
          wr_cnt_nxt    = N_LOG2'(1);
          frame_err_nxt = 1'b1;
        end else if (in_valid) begin
          wr_en      = 1'b1;
          wr_cnt_nxt = wr_cnt + 1'b1;
          if (wr_cnt == LAST_IDX) begin
            state_nxt  = ST_DRAIN;
            rd_ptr_nxt = '0;
          end
        end
      end

      ST_DRAIN: begin
        if (out_ready) begin
          rd_ptr_nxt = rd_ptr + 1'b1;
          if (rd_ptr == LAST_IDX) begin
            state_nxt = ST_IDLE;
            // A frame start on the final beat is taken so back-to-back
            // frames lose nothing.
            if (in_valid && in_first) begin
              wr_en      = 1'b1;
              wr_idx     = '0;
              wr_cnt_nxt = N_LOG2'(1);
              state_nxt  = ST_FILL;
            end else if (in_valid) begin
              drop = 1'b1;
            end
          end else if (in_valid) begin
            drop = 1'b1;
          end
        end else if (in_valid) begin
          drop = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      state     <= state_nxt;
      wr_cnt    <= wr_cnt_nxt;
      rd_ptr    <= rd_ptr_nxt;
      frame_err <= frame_err_nxt;
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      sample_buf[wr_addr] <= in_data;
    end
  end

  assign out_valid = (state == ST_DRAIN);
  assign out_index = out_valid ? rd_ptr : '0;
  assign out_data  = out_valid ? sample_buf[rd_ptr] : '0;
  assign out_last  = out_valid && (rd_ptr == LAST_IDX);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_fft_out_collector.sv
module tb_fft_out_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_first;
  logic [33:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_data;
  logic [3:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        frame_err;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [33:0] frame_in [16];
  logic [33:0] got_data [$];
  logic [3:0]  got_idx  [$];
  logic        got_last [$];

  fft_out_collector #(.N_LOG2(4), .DW(34), .BITREV(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .frame_err (frame_err),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Reference: sample k lands at bin reverse(k), so bin j holds sample reverse(j).
  function automatic int rev4(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) begin
      if ((k >> b) & 1) r = r | (1 << (3 - b));
    end
    return r;
  endfunction

  function automatic logic [33:0] exp_bin(input int j);
    return frame_in[rev4(j)];
  endfunction

  function automatic logic [33:0] rand_sample();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[33:0];
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 16; k++) frame_in[k] = rand_sample();
  endtask

  // Drives frame_in as one frame; reports out_valid seen while sample 15 is on the bus.
  task automatic send_frame(input bit gaps, output bit valid_before_last);
    valid_before_last = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (gaps && k != 0) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_first = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_first = (k == 0);
      in_data  = frame_in[k];
      if (k == 15) valid_before_last = out_valid;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_data  = '0;
  endtask

  // Collects one drained frame; optionally injects non-first samples while
  // the number of collected beats lies in [drop_lo, drop_hi].
  task automatic collect(input bit rand_ready, input int drop_lo, input int drop_hi,
                         output int cycles, output bit timed_out);
    bit done;
    done = 1'b0;
    cycles = 0;
    got_data.delete();
    got_idx.delete();
    got_last.delete();
    while (!done && cycles < 200) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (got_data.size() >= drop_lo) && (got_data.size() <= drop_hi);
      in_first  = 1'b0;
      in_data   = rand_sample();
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_idx.push_back(out_index);
        got_last.push_back(out_last);
        if (out_last) done = 1'b1;
      end
      @(negedge clk);
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (out_data !== 34'd0 || out_index !== 4'd0 || out_last !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got data=%0h idx=%0d last=%b expected 0/0/0", out_data, out_index, out_last);
    end
  endtask

  task automatic test_natural();
    int nat_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    bit vb, to;
    int cyc;
    do_reset();
    for (int k = 0; k < 16; k++) frame_in[k] = 34'(k);
    send_frame(1'b0, vb);
    checks++; if (vb !== 1'b0) begin errors++; $display("FAIL nat_valid_early: got %b expected 0", vb); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nat_valid_rise: got %b expected 1", out_valid); end
    collect(1'b0, -1, -2, cyc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL nat_timeout: drain did not finish"); end
    checks++; if (got_data.size() != 16) begin errors++; $display("FAIL nat_beats: got %0d expected 16", got_data.size()); end
    checks++; if (cyc != 16) begin errors++; $display("FAIL nat_drain_cycles: got %0d expected 16", cyc); end
    for (int j = 0; j < 16 && j < got_data.size(); j++) begin
      checks++; if (got_data[j] !== 34'(nat_tab[j])) begin errors++; $display("FAIL nat_data[%0d]: got %0d expected %0d", j, got_data[j], nat_tab[j]); end
      checks++; if (got_idx[j] !== 4'(j)) begin errors++; $display("FAIL nat_index[%0d]: got %0d expected %0d", j, got_idx[j], j); end
      checks++; if (got_last[j] !== (j == 15)) begin errors++; $display("FAIL nat_last[%0d]: got %b expected %b", j, got_last[j], (j == 15)); end
    end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nat_idle_after: got valid=%b busy=%b expected 0/0", out_valid, busy); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL nat_drop_cnt: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_backpressure();
    bit vb, stalled;
    logic [33:0] held_d;
    logic [3:0]  held_i;
    int n, cyc, ph;
    do_reset();
    fill_random();
    send_frame(1'b1, vb);
    n = 0; cyc = 0; ph = 0; stalled = 1'b0; held_d = '0; held_i = '0;
    while (n < 16 && cyc < 200) begin
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_index !== held_i) begin
          errors++; $display("FAIL bp_hold: got v=%b d=%0h i=%0d expected 1 d=%0h i=%0d", out_valid, out_data, out_index, held_d, held_i);
        end
      end
      out_ready = ((ph % 3) == 0);
      ph++;
      if (out_valid && out_ready) begin
        checks++; if (out_data !== exp_bin(n)) begin errors++; $display("FAIL bp_data[%0d]: got %0h expected %0h", n, out_data, exp_bin(n)); end
        checks++; if (out_index !== 4'(n)) begin errors++; $display("FAIL bp_index[%0d]: got %0d expected %0d", n, out_index, n); end
        checks++; if (out_last !== (n == 15)) begin errors++; $display("FAIL bp_last[%0d]: got %b expected %b", n, out_last, (n == 15)); end
        n++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held_d  = out_data;
        held_i  = out_index;
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL bp_transfers: got %0d expected 16", n); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle_after: got valid=%b busy=%b expected 0/0", out_valid, busy); end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit vb, to;
    logic [33:0] a_bins [16];
    int na, cyc;
    do_reset();
    fill_random();
    for (int j = 0; j < 16; j++) a_bins[j] = exp_bin(j);
    send_frame(1'b0, vb);
    out_ready = 1'b1;
    na = 0; cyc = 0;
    while (na < 16 && cyc < 100) begin
      if (out_valid) begin
        checks++; if (out_data !== a_bins[na]) begin errors++; $display("FAIL b2b_a_data[%0d]: got %0h expected %0h", na, out_data, a_bins[na]); end
        if (out_last) begin
          in_valid = 1'b1;
          in_first = 1'b1;
          in_data  = 34'd100;
        end
        na++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (na != 16) begin errors++; $display("FAIL b2b_a_beats: got %0d expected 16", na); end
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_fill_start: got busy=%b valid=%b expected 1/0", busy, out_valid); end
    for (int k = 1; k < 16; k++) begin
      in_valid = 1'b1;
      in_first = 1'b0;
      in_data  = 34'(100 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) frame_in[k] = 34'(100 + k);
    collect(1'b0, -1, -2, cyc, to);
    checks++; if (to !== 1'b0 || got_data.size() != 16) begin errors++; $display("FAIL b2b_b_beats: got %0d expected 16", got_data.size()); end
    for (int j = 0; j < 16 && j < got_data.size(); j++) begin
      checks++; if (got_data[j] !== exp_bin(j)) begin errors++; $display("FAIL b2b_b_data[%0d]: got %0d expected %0d", j, got_data[j], exp_bin(j)); end
    end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL b2b_drop_cnt: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_drops();
    bit vb, to;
    int cyc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_first = 1'b0;
      in_data  = rand_sample();
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL drop_idle: got %0d expected 3", drop_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy: got %b expected 0", busy); end
    fill_random();
    send_frame(1'b0, vb);
    collect(1'b0, 3, 4, cyc, to);
    checks++; if (to !== 1'b0 || got_data.size() != 16) begin errors++; $display("FAIL drop_drain_beats: got %0d expected 16", got_data.size()); end
    for (int j = 0; j < 16 && j < got_data.size(); j++) begin
      checks++; if (got_data[j] !== exp_bin(j)) begin errors++; $display("FAIL drop_drain_data[%0d]: got %0h expected %0h", j, got_data[j], exp_bin(j)); end
    end
    checks++; if (drop_cnt !== 8'd5) begin errors++; $display("FAIL drop_drain: got %0d expected 5", drop_cnt); end
    for (int i = 0; i < 250; i++) begin
      in_valid = 1'b1;
      in_first = 1'b0;
      in_data  = rand_sample();
      @(negedge clk);
    end
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_reach_max: got %0d expected 255", drop_cnt); end
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d expected 255", drop_cnt); end
  endtask

  task automatic test_restart();
    bit to;
    int cyc, err_seen, err_at;
    do_reset();
    fill_random();
    err_seen = 0; err_at = -1;
    for (int t = 0; t < 23; t++) begin
      in_valid = 1'b1;
      in_first = (t == 0) || (t == 7);
      in_data  = (t < 7) ? rand_sample() : frame_in[t - 7];
      @(negedge clk);
      if (frame_err === 1'b1) begin
        err_seen++;
        err_at = t;
      end
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    checks++; if (err_seen != 1) begin errors++; $display("FAIL restart_err_count: got %0d expected 1", err_seen); end
    checks++; if (err_at != 7) begin errors++; $display("FAIL restart_err_time: got %0d expected 7", err_at); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL restart_valid: got %b expected 1", out_valid); end
    collect(1'b1, -1, -2, cyc, to);
    checks++; if (to !== 1'b0 || got_data.size() != 16) begin errors++; $display("FAIL restart_beats: got %0d expected 16", got_data.size()); end
    for (int j = 0; j < 16 && j < got_data.size(); j++) begin
      checks++; if (got_data[j] !== exp_bin(j) || got_idx[j] !== 4'(j)) begin
        errors++; $display("FAIL restart_data[%0d]: got %0h/%0d expected %0h/%0d", j, got_data[j], got_idx[j], exp_bin(j), j);
      end
    end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL restart_drop_cnt: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    bit vb, to, found;
    int cyc;
    do_reset();
    fill_random();
    send_frame(1'b0, vb);
    out_ready = 1'b1;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 40) begin
      if (out_valid && out_index == 4'd5) found = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rmd_reach_bin5: bin 5 never presented"); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmd_async: got valid=%b busy=%b expected 0/0", out_valid, busy); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    fill_random();
    send_frame(1'b1, vb);
    collect(1'b1, -1, -2, cyc, to);
    checks++; if (to !== 1'b0 || got_data.size() != 16) begin errors++; $display("FAIL rmd_beats: got %0d expected 16", got_data.size()); end
    for (int j = 0; j < 16 && j < got_data.size(); j++) begin
      checks++; if (got_data[j] !== exp_bin(j)) begin errors++; $display("FAIL rmd_data[%0d]: got %0h expected %0h", j, got_data[j], exp_bin(j)); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_natural();
    test_backpressure();
    test_back_to_back();
    test_drops();
    test_restart();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_out_collector.md
Name: fft_out_collector

Overview:
- Receiving end of the FFT output stream. Captures one frame of N packed complex results from the fft core's data_out.
- Undoes bit-reversed output order and stores the frame in a local buffer.
- Drains the frame in natural order to a downstream consumer over a valid/ready handshake.
- Replaces ad-hoc $display capture with synthesizable result collection for on-chip readout and self-checking benches.

Parameters:
- N_LOG2, 4: log2 of frame length; N = 2**N_LOG2 samples per frame.
- DW, 34: sample width. {re_sign, re_int[7:0], re_frac[7:0], im_sign, im_int[7:0], im_frac[7:0]}.
- BITREV, 1: 1 = write address is the bit-reverse of the arrival count; 0 = identity addressing.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a valid FFT output sample this cycle.
- in_first  in  1  qualifies in_valid; marks sample 0 of a frame.
- in_data  in  DW  packed complex FFT output sample.
- out_valid  out  1  out_data/out_index/out_last are valid.
- out_ready  in  1  consumer accepts the current output.
- out_data  out  DW  sample in natural frequency order.
- out_index  out  N_LOG2  frequency bin of out_data.
- out_last  out  1  high with bin N-1.
- busy  out  1  high in FILL or DRAIN.
- frame_err  out  1  one-cycle pulse when in_first arrives mid-FILL.
- drop_cnt  out  8  saturating count of discarded in_valid samples.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; wr_cnt=0; rd_ptr=0; out_valid=0; frame_err=0; drop_cnt=0.
  - Buffer contents are not reset and are don't-care.
  - out_data and out_index are 0 when out_valid=0.
- Buffer: N x DW flop array.
  - Write address: BITREV ? bitrev(wr_cnt) : wr_cnt.
  - Read address: rd_ptr.
  - out_data = buf[rd_ptr], combinational from flops. Held stable while out_valid && !out_ready.
- State IDLE:
  - in_valid && in_first: write at address 0, wr_cnt<=1, go FILL.
  - in_valid && !in_first: sample discarded, drop_cnt++.
- State FILL:
  - in_valid && !in_first: write at addr(wr_cnt), wr_cnt++.
  - Write with wr_cnt==N-1: go DRAIN next cycle, rd_ptr<=0.
  - in_valid && in_first: frame_err pulses next cycle; frame restarts with the sample written at address 0 and wr_cnt<=1. The partial frame is abandoned and not counted as drops.
  - Gaps (in_valid=0) are allowed; no timeout.
- State DRAIN:
  - out_valid=1, out_index=rd_ptr, out_last=(rd_ptr==N-1).
  - On out_valid && out_ready: rd_ptr++.
  - On transfer with out_last: go IDLE; out_valid=0 next cycle unless a new frame starts.
  - in_valid during DRAIN: dropped, drop_cnt++. Exception: the final transfer cycle (below).
- Simultaneous final drain transfer and in_valid && in_first: the sample is accepted. Write at address 0, go FILL. Back-to-back frames therefore lose no sample when the consumer keeps out_ready=1.
- Latency: first out_valid appears 1 cycle after the cycle in which sample N-1 is written. With out_ready=1 the drain takes exactly N cycles.
- drop_cnt saturates at 255; it is cleared only by rst.
- Reset mid-FILL or mid-DRAIN: the frame is abandoned; out_valid falls asynchronously.
- Arithmetic: none on the data path; samples pass bit-exact.

Decomposition:
- Shared package fft_pkg holds:
  - DW=34 and field-offset constants (RE_SIGN=33, RE_INT_MSB=32, RE_FRAC_LSB=17, IM_SIGN=16, IM_FRAC_LSB=0).
  - Default N_LOG2.
  - Typedef cplx_t for the packed sample.
  - Bit-reverse function, parameterized by N_LOG2.
- One sub-module is natural: fft_bitrev_addr, a combinational N_LOG2-bit reverser. It is reused by the input-side loader.

Test Plan:
- Natural frame, N=16, BITREV=1: drive in_data=k for k=0..15, in_first on k=0, out_ready=1.
  - out_valid rises 1 cycle after k=15.
  - Out sequence (bins 0..15) = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - out_last is high on the 16th beat only.
- Backpressure: same frame, out_ready toggling 1,0,0,1,...
  - out_data and out_index are held across stall cycles.
  - Exactly 16 transfers occur, then IDLE.
- Back-to-back frames: frame B (values 100+k) starts with in_first in the same cycle as frame A's out_last transfer.
  - Frame B is fully captured and drains correctly.
  - drop_cnt=0.
- Drops: 3 samples with in_first=0 while IDLE, then 2 samples mid-DRAIN -> drop_cnt=5. Drive 300 drops -> drop_cnt=255.
- Restart: in_first asserted at sample 7 of a frame.
  - frame_err pulses once.
  - The following 16 samples form the drained frame.
- Reset mid-DRAIN at bin 5: out_valid drops immediately and busy=0. A new frame then collects and drains correctly.
